ring_johnson_dec: RTL and testbench
===================================

// Module: ring_johnson_dec
// PURPOSE
//   Decoder/checker for the 8-bit ring/Johnson counter output bus. Samples the code word,
//   decodes it to a binary position index, flags illegal codes and out-of-sequence steps,
//   and declares lock after a run of correct steps. Sits at the consumer end of the counter bus.
// PARAMETERS
//   WIDTH     8   code word width in bits
//   IDX_W     4   index width, $clog2(2*WIDTH)
//   ERR_W     8   error counter width
//   LOCK_CNT  3   consecutive good steps required to assert locked
// PORTS
//   clk       in   1       rising-edge clock
//   rst       in   1       asynchronous, active-low reset
//   ring      in   1       1 = ring (one-hot) code, 0 = Johnson code
//   mode      in   1       ring direction: 1 = rotate right {c[0],c[W-1:1]}, 0 = rotate left
//   valid_in  in   1       code_in is sampled this cycle
//   code_in   in   WIDTH   counter code word
//   err_clr   in   1       synchronous clear of err_cnt
//   index     out  IDX_W   decoded position of last legal sample
//   idx_valid out  1       1-cycle pulse: index updated
//   illegal   out  1       1-cycle pulse: sampled code not a legal word
//   step_err  out  1       1-cycle pulse: legal word, wrong successor
//   err_cnt   out  ERR_W   saturating count of illegal + step_err events
//   locked    out  1       level: sequence tracked correctly
// BEHAVIOUR
//   - All outputs registered; response appears one cycle after the valid_in sample.
//   - Reset (rst=0, async): index=0, idx_valid=0, illegal=0, step_err=0, err_cnt=0,
//     locked=0, state=ACQ, stored previous index/ring/mode = 0. Applies mid-operation.
//   - Ring legal: exactly one bit set; index = bit position (0..7). 0x00 and multi-hot illegal.
//   - Johnson legal: k=0..8 -> top k bits one, rest zero (0x00,0x80,..,0xFF);
//     k=9..15 -> top k-8 bits zero, rest one (0x7F,..,0x01). index = k. Else illegal.
//   - Expected successor: ring mode=1 -> (prev-1) mod 8; ring mode=0 -> (prev+1) mod 8;
//     Johnson -> (prev+1) mod 16, mode ignored. Wrap 0->7 / 7->0 / 15->0 is legal.
//   - States: ACQ (no reference), TRACK (good-step counter g), LOCKED.
//     ACQ:    legal -> store index, g=0, go TRACK; illegal -> illegal pulse, stay ACQ.
//     TRACK:  correct successor -> g+1; when g reaches LOCK_CNT -> LOCKED, locked=1.
//             wrong successor -> step_err, new sample becomes reference, g=0.
//     LOCKED: correct -> stay; wrong -> step_err, locked=0, TRACK, g=0.
//     Any state, illegal -> illegal pulse, locked=0, ACQ; index holds last legal value.
//   - ring or mode differing from value stored at previous sample -> treat sample as ACQ
//     (no step_err, locked=0); illegal still flagged.
//   - idx_valid pulses for every legal sample; no pulse for illegal or valid_in=0.
//   - valid_in=0: state, index, err_cnt, locked hold; pulses deassert.
//   - err_cnt += 1 per illegal or step_err event, saturates at all ones.
//     err_clr with simultaneous event -> err_cnt=1; err_clr alone -> 0.
// CONFIGURATION
//   RJDEC_HOLD_EN defined: sample equal to previous legal index (stalled counter) is
//     accepted: idx_valid pulses, no step_err, g unchanged, locked unchanged.
//   Not defined: repeated index is a wrong successor (step_err, rules above).
// TESTING
//   1 ring=1 mode=1, 0x01,0x80,0x40,0x20 -> index 0,7,6,5; locked=1 after 4th; err_cnt=0.
//   2 ring=0, 0x00,0x80..0xFF,0x7F..0x01,0x00 -> index 0..15 then 0; no step_err, locked=1.
//   3 ring=1 code 0x03, ring=0 code 0xA5 -> illegal each, err_cnt=2, locked=0, index holds.
//   4 locked ring mode=0, 0x02 then 0x08 -> step_err, index=3, locked=0, err_cnt+1.
//   5 err_cnt=0xFF + illegal -> stays 0xFF; err_clr with illegal -> 1; err_clr alone -> 0.
//   6 0x02,0x02 -> step_err without RJDEC_HOLD_EN, none with; rst=0 while locked -> all 0 at once.

Source files
------------

// File: rtl/ring_johnson_dec.sv
// ring_johnson_dec
//   Decoder/checker for an 8-bit ring (one-hot) or Johnson counter bus.
//   Samples code_in when valid_in is high and decodes it to a position index.
//   It flags illegal code words and legal words that are not the expected
//   successor, counts those errors, and asserts locked after LOCK_CNT
//   consecutive correct steps.
//
//   Optional feature: define RJDEC_HOLD_EN to accept a repeated index (a
//   stalled counter) as a good sample. Without it, a repeated index is a step
//   error.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   ring       1 = ring (one-hot) code, 0 = Johnson code
//   mode       ring direction: 1 = rotate right (index decrements), 0 = left
//   valid_in   code_in is sampled this cycle
//   code_in    counter code word
//   err_clr    synchronous clear of err_cnt
//   index      decoded position of the last legal sample
//   idx_valid  1-cycle pulse: index updated
//   illegal    1-cycle pulse: sampled word is not a legal code
//   step_err   1-cycle pulse: legal word but wrong successor
//   err_cnt    saturating count of illegal + step_err events
//   locked     level: sequence is being tracked correctly
module ring_johnson_dec #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned IDX_W    = $clog2(2*WIDTH),
   parameter int unsigned ERR_W    = 8,
   parameter int unsigned LOCK_CNT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ring,
   input  logic             mode,
   input  logic             valid_in,
   input  logic [WIDTH-1:0] code_in,
   input  logic             err_clr,
   output logic [IDX_W-1:0] index,
   output logic             idx_valid,
   output logic             illegal,
   output logic             step_err,
   output logic [ERR_W-1:0] err_cnt,
   output logic             locked
);

`ifdef RJDEC_HOLD_EN
   localparam bit HOLD_EN = 1'b1;
`else
   localparam bit HOLD_EN = 1'b0;
`endif

   localparam int unsigned G_W = $clog2(LOCK_CNT + 1);
   localparam logic [IDX_W-1:0] RING_LAST = IDX_W'(WIDTH - 1);
   localparam logic [IDX_W-1:0] JOHN_LAST = IDX_W'(2*WIDTH - 1);
   localparam logic [WIDTH-1:0] ALL_ONES  = '1;

   typedef enum logic [1:0] {ACQ, TRACK, LOCKED} state_e;

   state_e           state_q, state_d;
   logic [G_W-1:0]   g_q, g_d;
   logic [IDX_W-1:0] index_q, index_d;
   logic             ring_q, ring_d;
   logic             mode_q, mode_d;
   logic             idx_valid_q, idx_valid_d;
   logic             illegal_q, illegal_d;
   logic             step_err_q, step_err_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   logic             locked_q, locked_d;

   logic             dec_legal;
   logic [IDX_W-1:0] dec_idx;
   logic [IDX_W-1:0] exp_idx;
   logic [WIDTH-1:0] john_pat;
   logic             err_event;

   // Code word decode. Johnson word k is compared against its generated pattern:
   // k <= WIDTH has the top k bits set, and k > WIDTH has the top k-WIDTH bits clear.
   always_comb begin
      dec_legal = 1'b0;
      dec_idx   = '0;
      john_pat  = '0;
      if (ring) begin
         dec_legal = $onehot(code_in);
         for (int unsigned i = 0; i < WIDTH; i++) begin
            if (code_in[i]) dec_idx = IDX_W'(i);
         end
      end else begin
         for (int unsigned k = 0; k < 2*WIDTH; k++) begin
            if (k <= WIDTH) john_pat = ~(ALL_ONES >> k);
            else            john_pat = ALL_ONES >> (k - WIDTH);
            if (code_in == john_pat) begin
               dec_legal = 1'b1;
               dec_idx   = IDX_W'(k);
            end
         end
      end
   end

   // Expected successor of the stored reference index.
   always_comb begin
      exp_idx = '0;
      if (ring) begin
         if (mode) exp_idx = (index_q == '0)        ? RING_LAST : index_q - IDX_W'(1);
         else      exp_idx = (index_q == RING_LAST) ? '0        : index_q + IDX_W'(1);
      end else begin
         exp_idx = (index_q == JOHN_LAST) ? '0 : index_q + IDX_W'(1);
      end
   end

   // Next state and outputs
   always_comb begin
      state_d     = state_q;
      g_d         = g_q;
      index_d     = index_q;
      ring_d      = ring_q;
      mode_d      = mode_q;
      idx_valid_d = 1'b0;
      illegal_d   = 1'b0;
      step_err_d  = 1'b0;
      locked_d    = locked_q;

      if (valid_in) begin
         ring_d = ring;
         mode_d = mode;
         if (!dec_legal) begin
            illegal_d = 1'b1;
            locked_d  = 1'b0;
            state_d   = ACQ;
         end else begin
            idx_valid_d = 1'b1;
            index_d     = dec_idx;
            // A change of code type or direction invalidates the reference,
            // so the sample restarts acquisition instead of being judged.
            if (state_q == ACQ || ring != ring_q || mode != mode_q) begin
               state_d  = TRACK;
               g_d      = '0;
               locked_d = 1'b0;
            end else if (dec_idx == exp_idx) begin
               if (state_q == TRACK) begin
                  g_d = g_q + G_W'(1);
                  if (g_q + G_W'(1) == G_W'(LOCK_CNT)) begin
                     state_d  = LOCKED;
                     locked_d = 1'b1;
                  end
               end
            end else if (HOLD_EN && dec_idx == index_q) begin
               // A stalled counter is accepted: g, state and lock are unchanged.
               state_d = state_q;
            end else begin
               step_err_d = 1'b1;
               state_d    = TRACK;
               g_d        = '0;
               locked_d   = 1'b0;
            end
         end
      end

      err_event = illegal_d | step_err_d;
      err_cnt_d = err_cnt_q;
      if (err_clr)                             err_cnt_d = err_event ? ERR_W'(1) : '0;
      else if (err_event && err_cnt_q != '1)   err_cnt_d = err_cnt_q + ERR_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ACQ;
         g_q         <= '0;
         index_q     <= '0;
         ring_q      <= 1'b0;
         mode_q      <= 1'b0;
         idx_valid_q <= 1'b0;
         illegal_q   <= 1'b0;
         step_err_q  <= 1'b0;
         err_cnt_q   <= '0;
         locked_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         g_q         <= g_d;
         index_q     <= index_d;
         ring_q      <= ring_d;
         mode_q      <= mode_d;
         idx_valid_q <= idx_valid_d;
         illegal_q   <= illegal_d;
         step_err_q  <= step_err_d;
         err_cnt_q   <= err_cnt_d;
         locked_q    <= locked_d;
      end
   end

   assign index     = index_q;
   assign idx_valid = idx_valid_q;
   assign illegal   = illegal_q;
   assign step_err  = step_err_q;
   assign err_cnt   = err_cnt_q;
   assign locked    = locked_q;

endmodule

// File: tb/tb_ring_johnson_dec.sv
// Testbench for ring_johnson_dec. It runs directed vector tables, hand-written
// corner sequences, and random stimulus checked against a behavioural model.
module tb_ring_johnson_dec;

`ifdef RJDEC_HOLD_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ring = 1'b0, mode = 1'b0, valid_in = 1'b0, err_clr = 1'b0;
   logic [7:0] code_in = '0;
   logic [3:0] index;
   logic       idx_valid, illegal, step_err, locked;
   logic [7:0] err_cnt;

   ring_johnson_dec #(.WIDTH(8), .IDX_W(4), .ERR_W(8), .LOCK_CNT(3)) dut (
      .clk(clk), .rst(rst), .ring(ring), .mode(mode), .valid_in(valid_in),
      .code_in(code_in), .err_clr(err_clr), .index(index), .idx_valid(idx_valid),
      .illegal(illegal), .step_err(step_err), .err_cnt(err_cnt), .locked(locked)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   function automatic logic [15:0] pack(input logic [3:0] i, input logic iv, input logic il,
                                        input logic se, input logic [7:0] e, input logic l);
      return {i, iv, il, se, e, l};
   endfunction

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got idx/iv/ill/se/err/lock=%h required %h", name, got, exp);
   endtask

   function automatic logic [15:0] dut_out();
      return pack(index, idx_valid, illegal, step_err, err_cnt, locked);
   endfunction

   // Apply one cycle of inputs; outputs are readable when this returns.
   task automatic drive(input logic r, input logic m, input logic v, input logic [7:0] c,
                        input logic clr);
      @(negedge clk);
      ring = r; mode = m; valid_in = v; code_in = c; err_clr = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; valid_in = 1'b0; err_clr = 1'b0;
      #3;
      chk("reset_state", dut_out(), 16'h0000);
      @(negedge clk);
      rst = 1'b1;
   endtask

   // ---------------- behavioural reference model ----------------
   bit         m_ref;      // a legal reference sample exists
   int         m_good;
   bit         m_lock;
   int         m_idx;
   bit         m_pr, m_pm;
   int         m_err;

   function automatic int john_code(input int k);
      return (k <= 8) ? (256 - (1 << (8 - k))) : ((1 << (16 - k)) - 1);
   endfunction

   function automatic logic [7:0] encode(input bit r, input int k);
      return r ? 8'(1 << (k % 8)) : 8'(john_code(k % 16));
   endfunction

   function automatic int succ(input bit r, input bit m, input int p);
      if (r) return m ? (p + 7) % 8 : (p + 1) % 8;
      return (p + 1) % 16;
   endfunction

   task automatic model_reset();
      m_ref = 0; m_good = 0; m_lock = 0; m_idx = 0; m_pr = 0; m_pm = 0; m_err = 0;
   endtask

   task automatic model_step(input bit r, input bit m, input bit v, input logic [7:0] c,
                             input bit clr, output logic [15:0] exp);
      bit iv = 0, ill = 0, se = 0, ok = 0;
      int k = 0;
      if (v) begin
         for (int j = 0; j < 16; j++) begin
            if (r && j < 8 && c == 8'(1 << j)) begin ok = 1; k = j; end
            if (!r && c == 8'(john_code(j)))   begin ok = 1; k = j; end
         end
         if (!ok) begin
            ill = 1; m_lock = 0; m_ref = 0;
         end else begin
            iv = 1;
            if (!m_ref || r != m_pr || m != m_pm) begin
               m_ref = 1; m_good = 0; m_lock = 0;
            end else if (k == succ(r, m, m_idx)) begin
               if (!m_lock) begin
                  m_good++;
                  if (m_good >= 3) m_lock = 1;
               end
            end else if (HOLD && k == m_idx) begin
               m_good = m_good;
            end else begin
               se = 1; m_good = 0; m_lock = 0;
            end
            m_idx = k;
         end
         m_pr = r; m_pm = m;
      end
      if (clr)                          m_err = (ill || se) ? 1 : 0;
      else if ((ill || se) && m_err < 255) m_err++;
      exp = pack(4'(m_idx), iv, ill, se, 8'(m_err), m_lock);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic       r, m, v;
      logic [7:0] c;
      logic       clr;
      logic [3:0] ei;
      logic       eiv, eill, ese;
      logic [7:0] ee;
      logic       el;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, input logic m, input logic v, input logic [7:0] c,
                               input logic clr, input logic [3:0] ei, input logic eiv,
                               input logic eill, input logic ese, input logic [7:0] ee,
                               input logic el);
      vec_t t;
      t.r = r; t.m = m; t.v = v; t.c = c; t.clr = clr;
      t.ei = ei; t.eiv = eiv; t.eill = eill; t.ese = ese; t.ee = ee; t.el = el;
      return t;
   endfunction

   logic [15:0] exp_v;
   logic [7:0]  jc;
   bit          cr, cm;

   initial begin
      // ring right: 0,7,6,5 -> locked after the 4th sample
      tbl.push_back(mk(1,1,1,8'h01,0, 0,1,0,0,0,0));
      tbl.push_back(mk(1,1,1,8'h80,0, 7,1,0,0,0,0));
      tbl.push_back(mk(1,1,1,8'h40,0, 6,1,0,0,0,0));
      tbl.push_back(mk(1,1,1,8'h20,0, 5,1,0,0,0,1));
      // Johnson full cycle 0..15 then wrap to 0 (code type change restarts acquisition)
      for (int k = 0; k <= 16; k++) begin
         jc = 8'(john_code(k % 16));
         tbl.push_back(mk(0,0,1,jc,0, 4'(k % 16),1,0,0,0, (k >= 3) ? 1'b1 : 1'b0));
      end
      // valid_in low: everything holds, pulses low
      tbl.push_back(mk(0,0,0,8'h5A,0, 0,0,0,0,0,1));
      // illegal words in both code types: index holds
      tbl.push_back(mk(1,0,1,8'h03,0, 0,0,1,0,1,0));
      tbl.push_back(mk(0,0,1,8'hA5,0, 0,0,1,0,2,0));
      // ring left to lock, then 0x02 -> 0x08 step error
      tbl.push_back(mk(1,0,1,8'h10,0, 4,1,0,0,2,0));
      tbl.push_back(mk(1,0,1,8'h20,0, 5,1,0,0,2,0));
      tbl.push_back(mk(1,0,1,8'h40,0, 6,1,0,0,2,0));
      tbl.push_back(mk(1,0,1,8'h80,0, 7,1,0,0,2,1));
      tbl.push_back(mk(1,0,1,8'h01,0, 0,1,0,0,2,1));
      tbl.push_back(mk(1,0,1,8'h02,0, 1,1,0,0,2,1));
      tbl.push_back(mk(1,0,1,8'h08,0, 3,1,0,1,3,0));
      tbl.push_back(mk(1,0,1,8'h10,0, 4,1,0,0,3,0));
      // err_clr alone
      tbl.push_back(mk(1,0,0,8'h00,1, 4,0,0,0,0,0));
      // mode change while tracking: reacquire, no step_err
      tbl.push_back(mk(1,1,1,8'h01,0, 0,1,0,0,0,0));

      do_reset();
      foreach (tbl[i]) begin
         drive(tbl[i].r, tbl[i].m, tbl[i].v, tbl[i].c, tbl[i].clr);
         chk($sformatf("vec%0d", i), dut_out(),
             pack(tbl[i].ei, tbl[i].eiv, tbl[i].eill, tbl[i].ese, tbl[i].ee, tbl[i].el));
      end

      // err_cnt saturation and err_clr with a simultaneous event
      do_reset();
      for (int i = 0; i < 255; i++) drive(1, 0, 1, 8'h00, 0);
      chk("err_reach_ff", dut_out(), pack(0,0,1,0,8'hFF,0));
      drive(1, 0, 1, 8'h00, 0);
      chk("err_saturate", dut_out(), pack(0,0,1,0,8'hFF,0));
      drive(1, 0, 1, 8'h00, 1);
      chk("err_clr_event", dut_out(), pack(0,0,1,0,8'h01,0));
      drive(1, 0, 0, 8'h00, 1);
      chk("err_clr_alone", dut_out(), pack(0,0,0,0,8'h00,0));

      // repeated index, then lock, then asynchronous reset while locked
      do_reset();
      drive(1, 0, 1, 8'h02, 0);
      chk("rep_first", dut_out(), pack(1,1,0,0,0,0));
      drive(1, 0, 1, 8'h02, 0);
      chk("rep_second", dut_out(), HOLD ? pack(1,1,0,0,0,0) : pack(1,1,0,1,1,0));
      drive(1, 0, 1, 8'h04, 0);
      drive(1, 0, 1, 8'h08, 0);
      drive(1, 0, 1, 8'h10, 0);
      chk("rep_lock", dut_out(), pack(4,1,0,0, HOLD ? 8'd0 : 8'd1, 1));
      #2 rst = 1'b0;
      #1 chk("async_reset", dut_out(), 16'h0000);
      @(negedge clk);
      rst = 1'b1;

      // random stimulus against the behavioural model
      do_reset();
      model_reset();
      cr = 1; cm = 0;
      for (int n = 0; n < 600; n++) begin
         int sel;
         bit v, clr;
         logic [7:0] c;
         sel = int'($urandom_range(0, 99));
         if ($urandom_range(0, 99) < 4) cr = ~cr;
         if ($urandom_range(0, 99) < 4) cm = ~cm;
         clr = ($urandom_range(0, 99) < 3);
         v   = 1;
         if (sel < 60)      c = encode(cr, succ(cr, cm, m_idx));
         else if (sel < 72) c = encode(cr, m_idx);
         else if (sel < 82) c = encode(cr, int'($urandom_range(0, 15)));
         else if (sel < 92) c = 8'($urandom);
         else begin v = 0; c = 8'($urandom); end
         drive(cr, cm, v, c, clr);
         model_step(cr, cm, v, c, clr, exp_v);
         chk($sformatf("rand%0d", n), dut_out(), exp_v);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
